// File: rtl/mdu_alu_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that borrows the shared add/sub ALU.
// Shift-add multiply and restoring divide on magnitudes; signs are applied in FIX.
module mdu_alu_sequencer #(
    parameter int         DATA_W  = 32,
    parameter logic [3:0] ALU_ADD = 4'b0010,
    parameter logic [3:0] ALU_SUB = 4'b0110
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [1:0]        i_op,
    input  logic [DATA_W-1:0] i_src_a,
    input  logic [DATA_W-1:0] i_src_b,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo,
    output logic              o_div_by_zero,
    output logic              o_alu_req,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [3:0]        o_alu_control,
    input  logic [DATA_W-1:0] i_alu_result
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_is_div;
    logic                r_sa;
    logic                r_sb;
    logic [DATA_W-1:0]   r_a_abs;
    logic [DATA_W-1:0]   r_b_abs;
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]   r_wrk;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                r_busy;
    logic                r_done;
    logic                r_dbz;
    logic                r_alu_req;

    function automatic logic [DATA_W-1:0] f_neg(input logic [DATA_W-1:0] x);
        logic signed [DATA_W-1:0] s;
        s = signed'(x);
        return unsigned'(-s);
    endfunction

    function automatic logic [2*DATA_W-1:0] f_neg2(input logic [2*DATA_W-1:0] x);
        logic signed [2*DATA_W-1:0] s;
        s = signed'(x);
        return unsigned'(-s);
    endfunction

    logic                w_sa_in;
    logic                w_sb_in;
    logic [DATA_W-1:0]   w_a_abs_in;
    logic [DATA_W-1:0]   w_b_abs_in;
    logic [DATA_W-1:0]   w_div_p;
    logic                w_div_take;
    logic                w_carry;
    logic [DATA_W-1:0]   w_alu_a;
    logic [DATA_W-1:0]   w_alu_b;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_quo;
    logic [DATA_W-1:0]   w_rem;

    // Sign bits only matter for the signed ops; unsigned operands pass through raw.
    assign w_sa_in    = i_op[1] & i_src_a[DATA_W-1];
    assign w_sb_in    = i_op[1] & i_src_b[DATA_W-1];
    assign w_a_abs_in = w_sa_in ? f_neg(i_src_a) : i_src_a;
    assign w_b_abs_in = w_sb_in ? f_neg(i_src_b) : i_src_b;

    assign w_div_p    = {r_acc[DATA_W-2:0], r_wrk[DATA_W-1]};
    assign w_div_take = r_acc[DATA_W-1] | (w_div_p >= r_b_abs);
    assign w_carry    = i_alu_result < r_acc;

    assign w_alu_a = r_is_div ? w_div_p : r_acc;
    assign w_alu_b = (r_is_div || r_wrk[0]) ? r_b_abs : '0;

    assign w_prod = (r_sa ^ r_sb) ? f_neg2({r_acc, r_wrk}) : {r_acc, r_wrk};
    assign w_quo  = (r_sa ^ r_sb) ? f_neg(r_wrk) : r_wrk;
    assign w_rem  = r_sa ? f_neg(r_acc) : r_acc;

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_hi          = r_hi;
    assign o_lo          = r_lo;
    assign o_div_by_zero = r_dbz;
    assign o_alu_req     = r_alu_req;
    assign o_alu_a       = r_alu_req ? w_alu_a : '0;
    assign o_alu_b       = r_alu_req ? w_alu_b : '0;
    assign o_alu_control = (r_alu_req && r_is_div) ? ALU_SUB : ALU_ADD;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_alu_req <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start && !i_abort) begin
                        r_is_div <= i_op[0];
                        r_sa     <= w_sa_in;
                        r_sb     <= w_sb_in;
                        r_a_abs  <= w_a_abs_in;
                        r_b_abs  <= w_b_abs_in;
                        r_busy   <= 1'b1;
                        r_state  <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (i_abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= '0;
                        r_wrk <= r_a_abs;
                        r_cnt <= '0;
                        if (r_is_div && (r_b_abs == '0)) begin
                            // Re-signing |a| restores the raw dividend for hi.
                            r_hi    <= r_sa ? f_neg(r_a_abs) : r_a_abs;
                            r_lo    <= '1;
                            r_dbz   <= 1'b1;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_alu_req <= 1'b1;
                            r_state   <= S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    if (i_abort) begin
                        r_busy    <= 1'b0;
                        r_alu_req <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        if (r_is_div) begin
                            r_acc <= w_div_take ? i_alu_result : w_div_p;
                            r_wrk <= {r_wrk[DATA_W-2:0], w_div_take};
                        end else begin
                            r_acc <= {w_carry, i_alu_result[DATA_W-1:1]};
                            r_wrk <= {i_alu_result[0], r_wrk[DATA_W-1:1]};
                        end
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_LAST) begin
                            r_alu_req <= 1'b0;
                            r_state   <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (i_abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            r_hi <= w_prod[2*DATA_W-1:DATA_W];
                            r_lo <= w_prod[DATA_W-1:0];
                        end
                        r_dbz   <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy    <= 1'b0;
                    r_alu_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_alu_sequencer.sv
// Directed bench for mdu_alu_sequencer with a behavioural add/sub ALU attached.
module tb_mdu_alu_sequencer;

    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;

    logic        r_clk = 1'b0;
    logic        r_rst_n;
    logic        r_start;
    logic [1:0]  r_op;
    logic [31:0] r_src_a;
    logic [31:0] r_src_b;
    logic        r_abort;
    logic        w_busy;
    logic        w_done;
    logic [31:0] w_hi;
    logic [31:0] w_lo;
    logic        w_dbz;
    logic        w_alu_req;
    logic [31:0] w_alu_a;
    logic [31:0] w_alu_b;
    logic [3:0]  w_alu_control;
    logic [31:0] w_alu_result;

    int n_total = 0;
    int n_bad   = 0;

    always #5 r_clk = ~r_clk;

    assign w_alu_result = (w_alu_control == C_SUB) ? (w_alu_a - w_alu_b) : (w_alu_a + w_alu_b);

    mdu_alu_sequencer dut (
        .i_clk         (r_clk),
        .i_rst_n       (r_rst_n),
        .i_start       (r_start),
        .i_op          (r_op),
        .i_src_a       (r_src_a),
        .i_src_b       (r_src_b),
        .i_abort       (r_abort),
        .o_busy        (w_busy),
        .o_done        (w_done),
        .o_hi          (w_hi),
        .o_lo          (w_lo),
        .o_div_by_zero (w_dbz),
        .o_alu_req     (w_alu_req),
        .o_alu_a       (w_alu_a),
        .o_alu_b       (w_alu_b),
        .o_alu_control (w_alu_control),
        .i_alu_result  (w_alu_result)
    );

    task automatic t_check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start one op, follow it to done, check latency, results and ALU usage.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dbz,
                          input int exp_lat, input bit poke);
        int lat;
        int n_req;
        int n_badalu;
        logic [3:0] exp_ctl;
        exp_ctl = op[0] ? C_SUB : C_ADD;
        @(negedge r_clk);
        r_op    = op;
        r_src_a = a;
        r_src_b = b;
        r_start = 1'b1;
        @(posedge r_clk);
        #1;
        r_start  = 1'b0;
        lat      = 1;
        n_req    = 0;
        n_badalu = 0;
        t_check({tag, "_busy"}, 64'(w_busy), 64'(1));
        while (!w_done && lat < 60) begin
            if (w_alu_req) begin
                n_req++;
                if (w_alu_control !== exp_ctl) n_badalu++;
            end else if (w_alu_a !== 32'd0 || w_alu_b !== 32'd0 || w_alu_control !== C_ADD) begin
                n_badalu++;
            end
            if (poke && lat == 5) begin
                r_start = 1'b1;
                r_op    = ~op;
                r_src_a = 32'h1234_5678;
                r_src_b = 32'h0000_0003;
            end
            if (poke && lat == 6) r_start = 1'b0;
            @(posedge r_clk);
            #1;
            lat++;
        end
        t_check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        t_check({tag, "_hi"}, 64'(w_hi), 64'(exp_hi));
        t_check({tag, "_lo"}, 64'(w_lo), 64'(exp_lo));
        t_check({tag, "_dbz"}, 64'(w_dbz), 64'(exp_dbz));
        t_check({tag, "_busy_done"}, 64'(w_busy), 64'(0));
        t_check({tag, "_alu_cycles"}, 64'(n_req), exp_dbz ? 64'(0) : 64'(32));
        t_check({tag, "_alu_ctl"}, 64'(n_badalu), 64'(0));
        if (poke) r_start = 1'b1;
        @(posedge r_clk);
        #1;
        r_start = 1'b0;
        t_check({tag, "_done_pulse"}, 64'(w_done), 64'(0));
        t_check({tag, "_no_restart"}, 64'(w_busy), 64'(0));
        t_check({tag, "_hold_hi"}, 64'(w_hi), 64'(exp_hi));
    endtask

    initial begin
        int n_done;
        r_rst_n = 1'b0;
        r_start = 1'b0;
        r_abort = 1'b0;
        r_op    = 2'b00;
        r_src_a = 32'd0;
        r_src_b = 32'd0;
        repeat (2) @(posedge r_clk);
        #1;
        t_check("rst_busy", 64'(w_busy), 64'(0));
        t_check("rst_done", 64'(w_done), 64'(0));
        t_check("rst_hilo", {w_hi, w_lo}, 64'(0));
        t_check("rst_alu", {27'd0, w_alu_req, w_alu_a, w_alu_control}, {32'd0, 28'd0, C_ADD});
        @(negedge r_clk);
        r_rst_n = 1'b1;

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 35, 1'b0);
        run_op("mult_m7x3", 2'b10, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 35, 1'b1);
        run_op("mult_minx_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 35, 1'b0);
        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 35, 1'b0);
        run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 35, 1'b0);
        run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 35, 1'b0);
        run_op("divu_5_0", 2'b01, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 2, 1'b0);
        run_op("div_m9_0", 2'b11, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1, 2, 1'b0);
        run_op("divu_7_3", 2'b01, 32'd7, 32'd3, 32'd1, 32'd2, 1'b0, 35, 1'b0);

        // Abort at ITER count 10, with a simultaneous start that must be ignored.
        @(negedge r_clk);
        r_op    = 2'b00;
        r_src_a = 32'd1000;
        r_src_b = 32'd1000;
        r_start = 1'b1;
        @(posedge r_clk);
        #1;
        r_start = 1'b0;
        repeat (11) @(posedge r_clk);
        #1;
        t_check("abort_pre_req", 64'(w_alu_req), 64'(1));
        r_abort = 1'b1;
        r_start = 1'b1;
        @(posedge r_clk);
        #1;
        r_abort = 1'b0;
        r_start = 1'b0;
        t_check("abort_busy", 64'(w_busy), 64'(0));
        t_check("abort_req", 64'(w_alu_req), 64'(0));
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (w_done || w_busy) n_done++;
            @(posedge r_clk);
            #1;
        end
        t_check("abort_no_done", 64'(n_done), 64'(0));
        t_check("abort_hilo", {w_hi, w_lo}, {32'd1, 32'd2});
        t_check("abort_dbz", 64'(w_dbz), 64'(0));

        // Reset in the middle of a divide.
        @(negedge r_clk);
        r_op    = 2'b01;
        r_src_a = 32'd99;
        r_src_b = 32'd4;
        r_start = 1'b1;
        @(posedge r_clk);
        #1;
        r_start = 1'b0;
        repeat (6) @(posedge r_clk);
        #1;
        t_check("mid_alu_sub", {27'd0, w_alu_req, w_alu_control}, {59'd1, C_SUB});
        r_rst_n = 1'b0;
        r_start = 1'b1;
        @(posedge r_clk);
        #1;
        r_start = 1'b0;
        t_check("mrst_ctl", {60'd0, w_busy, w_done, w_dbz, w_alu_req}, 64'd0);
        t_check("mrst_hilo", {w_hi, w_lo}, 64'd0);
        t_check("mrst_alu", {w_alu_a, w_alu_b}, 64'd0);
        r_rst_n = 1'b1;
        @(posedge r_clk);
        #1;
        t_check("post_rst_idle", 64'(w_busy), 64'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
